mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/rv_ctrl_pkg.sv | 28 ++
 rtl/alu_decoder.sv | 25 ++
 rtl/mc_control.sv | 66 ++++++
 tb/tb_mc_control.sv | 96 +++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared state, opcode and ALU operation encodings for control and datapath
package rv_ctrl_pkg;
  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;
  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  typedef enum logic [2:0] {OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_NOP} op_class_e;
  // Anything not recognised becomes a NOP that only advances the PC.
  function automatic op_class_e op_class(input logic [6:0] opc);
    return opc == OPC_R ? OP_R : opc == OPC_I ? OP_I : opc == OPC_LW ? OP_LW :
           opc == OPC_SW ? OP_SW : opc == OPC_BEQ ? OP_BEQ : OP_NOP;
  endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: instruction class and funct fields to ALU operation select
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  op_class_e   cls_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7b5_i,
  output logic [3:0]  alu_ctrl_o
);
  logic [3:0] arith;
  // funct7[5] only selects SUB for R-type and SRA for both shift-right forms.
  always_comb begin
    case (funct3_i)
      3'b000:  arith = (cls_i == OP_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
      3'b001:  arith = ALU_SLL;
      3'b010:  arith = ALU_SLT;
      3'b100:  arith = ALU_XOR;
      3'b101:  arith = funct7b5_i ? ALU_SRA : ALU_SRL;
      3'b110:  arith = ALU_OR;
      3'b111:  arith = ALU_AND;
      default: arith = ALU_ADD;
    endcase
    alu_ctrl_o = (cls_i == OP_R || cls_i == OP_I) ? arith : cls_i == OP_BEQ ? ALU_SUB : ALU_ADD;
  end
endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle IF/ID/EX/MEM/WB control FSM decoding the latched instruction
module mc_control
  import rv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        PCSrc,
  output logic        loadPC,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [3:0]  ALUCtrl,
  output logic [2:0]  state
);
  logic [2:0]  state_q, state_d;
  logic [31:0] instr_q;
  logic        zero_q;
  op_class_e   cls;
  logic [3:0]  alu;
  logic        exe, mem, wb, mem_op;
  assign cls    = op_class(instr_q[6:0]);
  assign mem_op = cls == OP_LW || cls == OP_SW;
  alu_decoder u_dec (
    .cls_i      (cls),
    .funct3_i   (instr_q[14:12]),
    .funct7b5_i (instr_q[30]),
    .alu_ctrl_o (alu)
  );
  // Next state; WB and the unused codes 5-7 all return to IF.
  always_comb
    state_d = state_q == S_IF  ? S_ID :
              state_q == S_ID  ? S_EX :
              state_q == S_EX  ? (mem_op ? S_MEM : S_WB) :
              state_q == S_MEM ? (mem_ready ? S_WB : S_MEM) : S_IF;
  // State, instruction latch at end of IF, zero flag capture at end of EX.
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= S_IF;
      instr_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IF) instr_q <= instr;
      if (state_q == S_EX) zero_q <= Zero;
    end
  // Outputs are gated by rst so an aborted access drops in the cycle reset is seen.
  always_comb begin
    mem      = !rst && state_q == S_MEM;
    wb       = !rst && state_q == S_WB;
    exe      = !rst && (state_q == S_EX || state_q == S_MEM || state_q == S_WB);
    state    = rst ? S_IF : state_q;
    ALUCtrl  = exe ? alu : 4'b0000;
    ALUSrc   = exe && (cls == OP_I || mem_op);
    MemRead  = mem && cls == OP_LW;
    MemWrite = mem && cls == OP_SW;
    loadPC   = wb;
    PCSrc    = wb && cls == OP_BEQ && zero_q;
    RegWrite = wb && (cls == OP_R || cls == OP_I || cls == OP_LW);
    MemToReg = wb && cls == OP_LW;
  end
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: scoreboard bench for the multi-cycle control FSM
module tb_mc_control;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ALUSrc, RegWrite, MemToReg, PCSrc, loadPC, MemRead, MemWrite;
  logic [3:0]  ALUCtrl;
  logic [2:0]  state;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [13:0] exp_q[$];
  string       tag_q[$];

  mc_control dut (
    .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .mem_ready(mem_ready),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemToReg(MemToReg), .PCSrc(PCSrc),
    .loadPC(loadPC), .MemRead(MemRead), .MemWrite(MemWrite), .ALUCtrl(ALUCtrl), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected vector: state, ALUSrc, RegWrite, MemToReg, PCSrc, loadPC, MemRead, MemWrite, ALUCtrl
  function automatic logic [13:0] pk(input logic [2:0] st, input logic as, rw, mtr, pcs, lpc, mr, mw,
                                      input logic [3:0] alu);
    return {st, as, rw, mtr, pcs, lpc, mr, mw, alu};
  endfunction

  // Drive one cycle's inputs just after the edge and record what the DUT must show in it.
  task automatic cyc(input logic r, input logic [31:0] in, input logic z, input logic rdy,
                     input logic [13:0] e, input string tag);
    @(posedge clk);
    #1;
    rst = r; instr = in; Zero = z; mem_ready = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // One full instruction; inputs outside their relevant state are randomised to prove they are ignored.
  task automatic exec(input string nm, input logic [31:0] ins, input logic z, input int nwait,
                      input logic memop, input logic [3:0] alu, input logic as, rw, mtr, pcs, mr, mw);
    cyc(0, ins, 1'($urandom), 1'($urandom), pk(3'd0, 0, 0, 0, 0, 0, 0, 0, 4'h0), {nm, ".IF"});
    cyc(0, $urandom, 1'($urandom), 1'($urandom), pk(3'd1, 0, 0, 0, 0, 0, 0, 0, 4'h0), {nm, ".ID"});
    cyc(0, $urandom, z, 1'($urandom), pk(3'd2, as, 0, 0, 0, 0, 0, 0, alu), {nm, ".EX"});
    if (memop)
      for (int i = 0; i <= nwait; i++)
        cyc(0, $urandom, 1'($urandom), i == nwait, pk(3'd3, as, 0, 0, 0, 0, mr, mw, alu),
            $sformatf("%s.MEM%0d", nm, i));
    cyc(0, $urandom, 1'($urandom), 1'($urandom), pk(3'd4, as, rw, mtr, pcs, 1, 0, 0, alu), {nm, ".WB"});
  endtask

  initial
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0)
        check(tag_q.pop_front(),
              32'({state, ALUSrc, RegWrite, MemToReg, PCSrc, loadPC, MemRead, MemWrite, ALUCtrl}),
              32'(exp_q.pop_front()));
    end

  initial begin
    cyc(1, 32'h002081B3, 1, 1, pk(3'd0, 0, 0, 0, 0, 0, 0, 0, 4'h0), "reset0");
    cyc(1, 32'h0080A283, 1, 1, pk(3'd0, 0, 0, 0, 0, 0, 0, 0, 4'h0), "reset1");
    //    name      instr         Z  n  mem alu    as rw mtr pcs mr mw
    exec("add",   32'h002081B3, 0, 0, 0, 4'b0010, 0, 1, 0, 0, 0, 0);
    exec("lw",    32'h0080A283, 0, 3, 1, 4'b0010, 1, 1, 1, 0, 1, 0);
    exec("sw",    32'h0050A423, 0, 0, 1, 4'b0010, 1, 0, 0, 0, 0, 1);
    exec("beq_t", 32'h00208463, 1, 0, 0, 4'b0110, 0, 0, 0, 1, 0, 0);
    exec("beq_n", 32'h00208463, 0, 0, 0, 4'b0110, 0, 0, 0, 0, 0, 0);
    exec("srai",  32'h4020D193, 0, 0, 0, 4'b1010, 1, 1, 0, 0, 0, 0);
    exec("nop",   32'h0000007F, 1, 0, 0, 4'b0010, 0, 0, 0, 0, 0, 0);
    exec("sub",   32'h40208133, 0, 0, 0, 4'b0110, 0, 1, 0, 0, 0, 0);
    exec("or",    32'h0020E1B3, 0, 0, 0, 4'b0001, 0, 1, 0, 0, 0, 0);
    exec("addi7", 32'h40008093, 0, 0, 0, 4'b0010, 1, 1, 0, 0, 0, 0);
    exec("srli",  32'h0020D193, 0, 0, 0, 4'b1000, 1, 1, 0, 0, 0, 0);
    cyc(0, 32'h0050A423, 0, 1, pk(3'd0, 0, 0, 0, 0, 0, 0, 0, 4'h0), "swrst.IF");
    cyc(0, $urandom, 0, 1, pk(3'd1, 0, 0, 0, 0, 0, 0, 0, 4'h0), "swrst.ID");
    cyc(0, $urandom, 0, 0, pk(3'd2, 1, 0, 0, 0, 0, 0, 0, 4'b0010), "swrst.EX");
    cyc(0, $urandom, 0, 0, pk(3'd3, 1, 0, 0, 0, 0, 0, 1, 4'b0010), "swrst.MEM0");
    cyc(1, $urandom, 0, 1, pk(3'd0, 0, 0, 0, 0, 0, 0, 0, 4'h0), "swrst.RST");
    exec("post",  32'h002081B3, 0, 0, 0, 4'b0010, 0, 1, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
